// File: rtl/cpuy_pkg.sv
// Shared constants for the cpuy execution peripherals.
// Covers the ALU function codes, the stack depth and the timer direction encoding.
package cpuy_pkg;

   localparam int STACK_DEPTH_DEF = 8;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   typedef enum logic [3:0] {
      FN_ADD  = 4'h0,
      FN_ADC  = 4'h1,
      FN_SUB  = 4'h2,
      FN_SBB  = 4'h3,
      FN_AND  = 4'h4,
      FN_OR   = 4'h5,
      FN_XOR  = 4'h6,
      FN_NOT  = 4'h7,
      FN_SHL  = 4'h8,
      FN_SHR  = 4'h9,
      FN_RLC  = 4'hA,
      FN_RRC  = 4'hB,
      FN_MUL  = 4'hC,
      FN_INC  = 4'hD,
      FN_DEC  = 4'hE,
      FN_PASS = 4'hF
   } alu_fn_e;

   function automatic logic [15:0] timer_terminal(input logic dir);
      return (dir == DIR_UP) ? 16'hFFFF : 16'h0000;
   endfunction

endpackage

// File: rtl/cpuy_timer.sv
// 16-bit up/down timer with a reload register and a sticky done flag.
// A load takes priority over counting; an ack takes priority over a terminal hit.
module cpuy_timer
   import cpuy_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        set_i,
   input  logic        dir_i,
   input  logic        reload_i,
   input  logic        ack_i,
   input  logic [15:0] count_i,
   output logic        done_o
);

   logic [15:0] cnt_q, cnt_d;
   logic [15:0] rld_q, rld_d;
   logic        done_q, done_d;
   logic        hit;

   always_comb begin
      cnt_d  = cnt_q;
      rld_d  = rld_q;
      done_d = done_q;
      hit    = 1'b0;
      if (set_i) begin
         cnt_d = count_i;
         rld_d = count_i;
      end else if (en_i) begin
         if (cnt_q == timer_terminal(dir_i)) begin
            hit = 1'b1;
            // Without reload the counter parks at the terminal value.
            if (reload_i) cnt_d = rld_q;
         end else if (dir_i == DIR_UP) begin
            cnt_d = cnt_q + 16'd1;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end
      if (ack_i)    done_d = 1'b0;
      else if (hit) done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         rld_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rld_q  <= rld_d;
         done_q <= done_d;
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/cpuy_periph.sv
// Execution peripherals of the cpuy CPU: combinational ALU, return-address
// stack and two independent timers feeding the interrupt logic.
module cpuy_periph
   import cpuy_pkg::*;
#(
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_en,
   input  logic [7:0]  alu_op,
   input  logic [7:0]  alu_a,
   input  logic [7:0]  alu_b,
   input  logic        alu_cin,
   output logic [7:0]  alu_res_l,
   output logic [7:0]  alu_res_h,
   output logic        alu_c,
   output logic        alu_z,
   output logic        alu_s,
   input  logic        stk_en,
   input  logic        stk_push,
   input  logic [11:0] stk_din,
   output logic [15:0] stk_dout,
   output logic        stk_full,
   output logic        stk_empty,
   input  logic        t0_en,
   input  logic        t0_set,
   input  logic        t0_dir,
   input  logic        t0_reload,
   input  logic        t0_ack,
   input  logic [15:0] t0_count,
   output logic        t0_done,
   input  logic        t1_en,
   input  logic        t1_set,
   input  logic        t1_dir,
   input  logic        t1_reload,
   input  logic        t1_ack,
   input  logic [15:0] t1_count,
   output logic        t1_done
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;

   alu_fn_e     fn;
   logic [8:0]  sum9;
   logic [15:0] prod;
   logic        unused_op;

   assign fn        = alu_fn_e'(alu_op[4:1]);
   assign unused_op = ^{alu_op[7:5], alu_op[0]};

   always_comb begin
      alu_res_l = '0;
      alu_res_h = '0;
      alu_c     = 1'b0;
      alu_z     = 1'b0;
      alu_s     = 1'b0;
      sum9      = '0;
      prod      = 16'(alu_a) * 16'(alu_b);
      if (alu_en && !rst) begin
         case (fn)
            FN_ADD:  sum9 = {1'b0, alu_a} + {1'b0, alu_b};
            FN_ADC:  sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
            FN_SUB:  sum9 = {1'b0, alu_a} - {1'b0, alu_b};
            FN_SBB:  sum9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
            FN_AND:  sum9 = {1'b0, alu_a & alu_b};
            FN_OR:   sum9 = {1'b0, alu_a | alu_b};
            FN_XOR:  sum9 = {1'b0, alu_a ^ alu_b};
            FN_NOT:  sum9 = {1'b0, ~alu_a};
            FN_SHL:  sum9 = {alu_a[7], alu_a[6:0], 1'b0};
            FN_SHR:  sum9 = {alu_a[0], 1'b0, alu_a[7:1]};
            FN_RLC:  sum9 = {alu_a[7], alu_a[6:0], alu_cin};
            FN_RRC:  sum9 = {alu_a[0], alu_cin, alu_a[7:1]};
            FN_INC:  sum9 = {1'b0, alu_a} + 9'd1;
            FN_DEC:  sum9 = {1'b0, alu_a} - 9'd1;
            FN_PASS: sum9 = {1'b0, alu_b};
            default: sum9 = '0;
         endcase
         // Bit 8 of sum9 is the carry, borrow or shifted-out bit for non-MUL ops.
         if (fn == FN_MUL) begin
            alu_res_l = prod[7:0];
            alu_res_h = prod[15:8];
            alu_z     = (prod == 16'h0000);
            alu_s     = prod[15];
         end else begin
            alu_res_l = sum9[7:0];
            alu_c     = sum9[8];
            alu_z     = (sum9[7:0] == 8'h00);
            alu_s     = sum9[7];
         end
      end
   end

   logic [SP_W-1:0] sp_q, sp_d;
   logic [11:0]     mem_q [STACK_DEPTH];
   logic [11:0]     dout_q;
   logic [SP_W-1:0] sp_m1;
   logic            push_ok, pop_ok;

   assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
   assign stk_empty = (sp_q == '0);
   assign push_ok   = stk_en &  stk_push & ~stk_full;
   assign pop_ok    = stk_en & ~stk_push & ~stk_empty;
   assign sp_m1     = sp_q - SP_W'(1);

   always_comb begin
      sp_d = sp_q;
      if (push_ok)     sp_d = sp_q + SP_W'(1);
      else if (pop_ok) sp_d = sp_m1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q   <= '0;
         dout_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q <= sp_d;
         if (push_ok) mem_q[sp_q[IDX_W-1:0]] <= stk_din;
         if (pop_ok)  dout_q <= mem_q[sp_m1[IDX_W-1:0]];
      end
   end

   assign stk_dout = {4'b0000, dout_q};

   cpuy_timer u_t0 (
      .clk      (clk),
      .rst      (rst),
      .en_i     (t0_en),
      .set_i    (t0_set),
      .dir_i    (t0_dir),
      .reload_i (t0_reload),
      .ack_i    (t0_ack),
      .count_i  (t0_count),
      .done_o   (t0_done)
   );

   cpuy_timer u_t1 (
      .clk      (clk),
      .rst      (rst),
      .en_i     (t1_en),
      .set_i    (t1_set),
      .dir_i    (t1_dir),
      .reload_i (t1_reload),
      .ack_i    (t1_ack),
      .count_i  (t1_count),
      .done_o   (t1_done)
   );

endmodule

// File: tb/tb_cpuy_periph.sv
// Directed bench for cpuy_periph: ALU vector table, stack LIFO/limits,
// timer down/up-reload behaviour and reset in mid-operation.
module tb_cpuy_periph;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_en, alu_cin;
   logic [7:0]  alu_op, alu_a, alu_b;
   logic [7:0]  alu_res_l, alu_res_h;
   logic        alu_c, alu_z, alu_s;
   logic        stk_en, stk_push;
   logic [11:0] stk_din;
   logic [15:0] stk_dout;
   logic        stk_full, stk_empty;
   logic        t0_en, t0_set, t0_dir, t0_reload, t0_ack, t0_done;
   logic        t1_en, t1_set, t1_dir, t1_reload, t1_ack, t1_done;
   logic [15:0] t0_count, t1_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cpuy_periph dut (
      .clk(clk), .rst(rst),
      .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_res_l(alu_res_l), .alu_res_h(alu_res_h), .alu_c(alu_c), .alu_z(alu_z), .alu_s(alu_s),
      .stk_en(stk_en), .stk_push(stk_push), .stk_din(stk_din), .stk_dout(stk_dout),
      .stk_full(stk_full), .stk_empty(stk_empty),
      .t0_en(t0_en), .t0_set(t0_set), .t0_dir(t0_dir), .t0_reload(t0_reload),
      .t0_ack(t0_ack), .t0_count(t0_count), .t0_done(t0_done),
      .t1_en(t1_en), .t1_set(t1_set), .t1_dir(t1_dir), .t1_reload(t1_reload),
      .t1_ack(t1_ack), .t1_count(t1_count), .t1_done(t1_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] v);
      stk_en = 1'b1; stk_push = 1'b1; stk_din = v;
      tick();
      stk_en = 1'b0; stk_push = 1'b0;
   endtask

   task automatic pop();
      stk_en = 1'b1; stk_push = 1'b0;
      tick();
      stk_en = 1'b0;
   endtask

   // f, a, b, cin, expected {res_h, res_l, c, z, s}
   typedef struct {
      logic [3:0]  f;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        cin;
      logic [18:0] exp;
   } alu_vec_t;

   alu_vec_t vecs[17] = '{
      '{4'h0, 8'hF0, 8'h20, 1'b0, {8'h00, 8'h10, 3'b100}},
      '{4'h1, 8'h7F, 8'h00, 1'b1, {8'h00, 8'h80, 3'b001}},
      '{4'h2, 8'h55, 8'h55, 1'b0, {8'h00, 8'h00, 3'b010}},
      '{4'h3, 8'h00, 8'h00, 1'b1, {8'h00, 8'hFF, 3'b101}},
      '{4'h2, 8'h10, 8'h20, 1'b0, {8'h00, 8'hF0, 3'b101}},
      '{4'h4, 8'hF0, 8'h3C, 1'b0, {8'h00, 8'h30, 3'b000}},
      '{4'h5, 8'hF0, 8'h0F, 1'b0, {8'h00, 8'hFF, 3'b001}},
      '{4'h6, 8'hFF, 8'hFF, 1'b0, {8'h00, 8'h00, 3'b010}},
      '{4'h7, 8'h0F, 8'h99, 1'b0, {8'h00, 8'hF0, 3'b001}},
      '{4'h8, 8'h81, 8'h00, 1'b0, {8'h00, 8'h02, 3'b100}},
      '{4'h9, 8'h81, 8'h00, 1'b0, {8'h00, 8'h40, 3'b100}},
      '{4'hA, 8'h80, 8'h00, 1'b1, {8'h00, 8'h01, 3'b100}},
      '{4'hB, 8'h01, 8'h00, 1'b1, {8'h00, 8'h80, 3'b101}},
      '{4'hC, 8'h10, 8'h10, 1'b0, {8'h01, 8'h00, 3'b000}},
      '{4'hC, 8'h00, 8'h37, 1'b0, {8'h00, 8'h00, 3'b010}},
      '{4'hD, 8'hFF, 8'h00, 1'b0, {8'h00, 8'h00, 3'b110}},
      '{4'hE, 8'h00, 8'h00, 1'b0, {8'h00, 8'hFF, 3'b101}}
   };

   function automatic logic [18:0] alu_obs();
      return {alu_res_h, alu_res_l, alu_c, alu_z, alu_s};
   endfunction

   initial begin
      rst = 1'b1;
      alu_en = 1'b0; alu_op = '0; alu_a = '0; alu_b = '0; alu_cin = 1'b0;
      stk_en = 1'b0; stk_push = 1'b0; stk_din = '0;
      t0_en = 0; t0_set = 0; t0_dir = 0; t0_reload = 0; t0_ack = 0; t0_count = '0;
      t1_en = 0; t1_set = 0; t1_dir = 0; t1_reload = 0; t1_ack = 0; t1_count = '0;
      tick(); tick();
      rst = 1'b0;
      #1;

      check("rst_dout",  32'(stk_dout), 32'h0);
      check("rst_empty", 32'(stk_empty), 32'h1);
      check("rst_full",  32'(stk_full), 32'h0);
      check("rst_done",  32'({t0_done, t1_done}), 32'h0);

      // ALU table; unused opcode bits set to show they are ignored
      alu_en = 1'b1;
      foreach (vecs[i]) begin
         alu_op = {3'b101, vecs[i].f, 1'b1};
         alu_a = vecs[i].a; alu_b = vecs[i].b; alu_cin = vecs[i].cin;
         #1;
         check($sformatf("alu_%0d_f%h", i, vecs[i].f), 32'(alu_obs()), 32'(vecs[i].exp));
      end
      alu_op = 8'h1E; alu_a = 8'h12; alu_b = 8'hA5; alu_cin = 1'b1; #1;
      check("alu_passb", 32'(alu_obs()), 32'({8'h00, 8'hA5, 3'b001}));
      alu_en = 1'b0; #1;
      check("alu_dis", 32'(alu_obs()), 32'h0);

      // Stack basic LIFO
      push(12'h123);
      check("stk_nempty", 32'(stk_empty), 32'h0);
      push(12'h456);
      pop();
      check("stk_pop1", 32'(stk_dout), 32'h0456);
      pop();
      check("stk_pop2", 32'(stk_dout), 32'h0123);
      check("stk_empty2", 32'(stk_empty), 32'h1);
      pop();
      check("stk_pop3", 32'(stk_dout), 32'h0123);
      check("stk_empty3", 32'(stk_empty), 32'h1);

      // Stack full and overflow
      for (int i = 0; i < 8; i++) begin
         check($sformatf("stk_nfull%0d", i), 32'(stk_full), 32'h0);
         push(12'h100 + 12'(i));
      end
      check("stk_full", 32'(stk_full), 32'h1);
      push(12'hFFF);
      check("stk_full9", 32'(stk_full), 32'h1);
      check("stk_dout9", 32'(stk_dout), 32'h0123);
      for (int i = 7; i >= 0; i--) begin
         pop();
         check($sformatf("stk_lifo%0d", i), 32'(stk_dout), 32'h100 + 32'(i));
      end
      check("stk_empty_end", 32'(stk_empty), 32'h1);

      // Timer 0: down, no reload, count=3
      t0_set = 1'b1; t0_count = 16'd3; t0_en = 1'b1; t0_dir = 1'b0;
      tick();
      t0_set = 1'b0;
      tick(); tick(); tick();
      check("t0_early", 32'(t0_done), 32'h0);
      tick();
      check("t0_done", 32'(t0_done), 32'h1);
      check("t0_cnt0", 32'(dut.u_t0.cnt_q), 32'h0);
      tick();
      check("t0_hold", 32'(dut.u_t0.cnt_q), 32'h0);
      check("t1_indep", 32'(t1_done), 32'h0);
      t0_en = 1'b0; t0_ack = 1'b1;
      tick();
      t0_ack = 1'b0;
      check("t0_ack", 32'(t0_done), 32'h0);
      tick(); tick();
      check("t0_stay0", 32'(t0_done), 32'h0);

      // Timer 1: up, auto-reload from FFFE
      t1_set = 1'b1; t1_count = 16'hFFFE; t1_dir = 1'b1; t1_reload = 1'b1; t1_en = 1'b1;
      tick();
      t1_set = 1'b0;
      tick();
      check("t1_cntFFFF", 32'(dut.u_t1.cnt_q), 32'hFFFF);
      check("t1_early", 32'(t1_done), 32'h0);
      tick();
      check("t1_done", 32'(t1_done), 32'h1);
      check("t1_reload", 32'(dut.u_t1.cnt_q), 32'hFFFE);
      tick();
      check("t1_sticky", 32'(t1_done), 32'h1);
      t1_ack = 1'b1;
      tick();
      t1_ack = 1'b0;
      check("t1_ackwins", 32'(t1_done), 32'h0);
      check("t1_reload2", 32'(dut.u_t1.cnt_q), 32'hFFFE);
      tick();
      check("t1_after_ack", 32'(t1_done), 32'h0);
      tick();
      check("t1_again", 32'(t1_done), 32'h1);
      t1_en = 1'b0;

      // Reset in mid-operation
      push(12'hABC);
      t0_set = 1'b1; t0_count = 16'd5; t0_en = 1'b1;
      tick();
      t0_set = 1'b0;
      tick();
      rst = 1'b1; alu_en = 1'b1; alu_op = 8'h00; alu_a = 8'hF0; alu_b = 8'h20; #1;
      check("alu_in_rst", 32'(alu_obs()), 32'h0);
      tick();
      rst = 1'b0; alu_en = 1'b0; t0_en = 1'b0;
      #1;
      check("mrst_done", 32'({t0_done, t1_done}), 32'h0);
      check("mrst_empty", 32'(stk_empty), 32'h1);
      check("mrst_cnt", 32'({dut.u_t0.cnt_q, dut.u_t1.cnt_q}), 32'h0);
      check("mrst_dout", 32'(stk_dout), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
